// File: rtl/rob_complete_pkg.sv
// Shared types and constants for the reorder buffer: row layout, sizes and opcodes.
package rob_complete_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int ROB_IDX_W = 4;
    localparam int PREG_W    = 6;
    localparam int DATA_W    = 32;
    localparam int OP_W      = 7;

    localparam logic [OP_W-1:0] OP_SW = 7'b0100011;
    localparam logic [OP_W-1:0] OP_LW = 7'b0000011;
    localparam logic [OP_W-1:0] OP_R  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I  = 7'b0010011;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic [PREG_W-1:0] pd;
        logic [PREG_W-1:0] opd;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] data;
    } rob_row;

endpackage

// File: rtl/rob_complete.sv
// Reorder buffer: dual allocation from dispatch, three FU completion ports,
// one-cycle wakeup echo and in-order dual retire with free-list return.
module rob_complete
    import rob_complete_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 u_rob,
    input  logic [PREG_W-1:0]    rob_p_1,
    input  logic [PREG_W-1:0]    rob_p_2,
    input  logic [OP_W-1:0]      rob_op_1,
    input  logic [OP_W-1:0]      rob_op_2,
    input  logic [PREG_W-1:0]    o_rob_p_1,
    input  logic [PREG_W-1:0]    o_rob_p_2,
    output logic [ROB_IDX_W-1:0] alloc_idx_1,
    output logic [ROB_IDX_W-1:0] alloc_idx_2,
    output logic                 rob_full,
    input  logic                 result_valid_1,
    input  logic                 result_valid_2,
    input  logic                 result_valid_3,
    input  logic [ROB_IDX_W-1:0] result_ROB_1,
    input  logic [ROB_IDX_W-1:0] result_ROB_2,
    input  logic [ROB_IDX_W-1:0] result_ROB_3,
    input  logic [PREG_W-1:0]    result_dest_1,
    input  logic [PREG_W-1:0]    result_dest_2,
    input  logic [PREG_W-1:0]    result_dest_3,
    input  logic [DATA_W-1:0]    result_1,
    input  logic [DATA_W-1:0]    result_2,
    input  logic [DATA_W-1:0]    result_3,
    output logic                 f_flag_1,
    output logic                 f_flag_2,
    output logic                 f_flag_3,
    output logic [PREG_W-1:0]    dest_r_1,
    output logic [PREG_W-1:0]    dest_r_2,
    output logic [PREG_W-1:0]    dest_r_3,
    output logic [DATA_W-1:0]    f_data_1,
    output logic [DATA_W-1:0]    f_data_2,
    output logic [DATA_W-1:0]    f_data_3,
    output logic                 ret_valid_1,
    output logic                 ret_valid_2,
    output logic [PREG_W-1:0]    ret_pd_1,
    output logic [PREG_W-1:0]    ret_pd_2,
    output logic [DATA_W-1:0]    ret_data_1,
    output logic [DATA_W-1:0]    ret_data_2,
    output logic                 ret_we_1,
    output logic                 ret_we_2,
    output logic [PREG_W-1:0]    free_preg_1,
    output logic [PREG_W-1:0]    free_preg_2,
    output logic                 rob_err
);

    rob_row               rows [ROB_DEPTH];
    logic [ROB_IDX_W-1:0] head;
    logic [ROB_IDX_W-1:0] head_p1;
    logic [ROB_IDX_W-1:0] tail;
    logic [ROB_IDX_W:0]   count;

    logic                 alloc_ok;
    logic                 fire_1;
    logic                 fire_2;
    logic                 we_1;
    logic                 we_2;
    logic [1:0]           retire_cnt;

    logic                 res_valid [3];
    logic [ROB_IDX_W-1:0] res_idx   [3];
    logic [DATA_W-1:0]    res_data  [3];

    assign alloc_idx_1 = tail;
    assign alloc_idx_2 = tail + 4'd1;
    assign rob_full    = (count > 5'(ROB_DEPTH - 2));
    assign alloc_ok    = u_rob && !rob_full;

    always_comb begin
        res_valid[0] = result_valid_1;
        res_valid[1] = result_valid_2;
        res_valid[2] = result_valid_3;
        res_idx[0]   = result_ROB_1;
        res_idx[1]   = result_ROB_2;
        res_idx[2]   = result_ROB_3;
        res_data[0]  = result_1;
        res_data[1]  = result_2;
        res_data[2]  = result_3;
    end

    // Retire looks only at registered done bits, so a same-cycle completion waits a cycle.
    always_comb begin
        head_p1    = head + 4'd1;
        fire_1     = rows[head].valid && rows[head].done;
        fire_2     = fire_1 && rows[head_p1].valid && rows[head_p1].done;
        we_1       = fire_1 && (rows[head].op != OP_SW) && (rows[head].pd != '0);
        we_2       = fire_2 && (rows[head_p1].op != OP_SW) && (rows[head_p1].pd != '0);
        retire_cnt = {1'b0, fire_1} + {1'b0, fire_2};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ROB_DEPTH; i++) rows[i] <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            rob_err     <= 1'b0;
            f_flag_1    <= 1'b0;
            f_flag_2    <= 1'b0;
            f_flag_3    <= 1'b0;
            dest_r_1    <= '0;
            dest_r_2    <= '0;
            dest_r_3    <= '0;
            f_data_1    <= '0;
            f_data_2    <= '0;
            f_data_3    <= '0;
            ret_valid_1 <= 1'b0;
            ret_valid_2 <= 1'b0;
            ret_pd_1    <= '0;
            ret_pd_2    <= '0;
            ret_data_1  <= '0;
            ret_data_2  <= '0;
            ret_we_1    <= 1'b0;
            ret_we_2    <= 1'b0;
            free_preg_1 <= '0;
            free_preg_2 <= '0;
        end else begin
            if (u_rob && rob_full) rob_err <= 1'b1;
            if (alloc_ok) begin
                rows[tail]        <= '{valid: 1'b1, done: 1'b0, pd: rob_p_1, opd: o_rob_p_1,
                                       op: rob_op_1, data: '0};
                rows[tail + 4'd1] <= '{valid: 1'b1, done: 1'b0, pd: rob_p_2, opd: o_rob_p_2,
                                       op: rob_op_2, data: '0};
                tail              <= tail + 4'd2;
            end

            // Later ports overwrite earlier ones on a shared index.
            for (int k = 0; k < 3; k++) begin
                if (res_valid[k]) begin
                    if (rows[res_idx[k]].valid) begin
                        rows[res_idx[k]].done <= 1'b1;
                        rows[res_idx[k]].data <= res_data[k];
                    end else begin
                        rob_err <= 1'b1;
                    end
                end
            end

            if (fire_1) rows[head]    <= '0;
            if (fire_2) rows[head_p1] <= '0;
            head  <= head + {2'b00, retire_cnt};
            count <= count + {3'b000, alloc_ok, 1'b0} - {3'b000, retire_cnt};

            f_flag_1    <= result_valid_1;
            f_flag_2    <= result_valid_2;
            f_flag_3    <= result_valid_3;
            dest_r_1    <= result_dest_1;
            dest_r_2    <= result_dest_2;
            dest_r_3    <= result_dest_3;
            f_data_1    <= result_1;
            f_data_2    <= result_2;
            f_data_3    <= result_3;

            ret_valid_1 <= fire_1;
            ret_valid_2 <= fire_2;
            ret_pd_1    <= fire_1 ? rows[head].pd : '0;
            ret_pd_2    <= fire_2 ? rows[head_p1].pd : '0;
            ret_data_1  <= fire_1 ? rows[head].data : '0;
            ret_data_2  <= fire_2 ? rows[head_p1].data : '0;
            ret_we_1    <= we_1;
            ret_we_2    <= we_2;
            free_preg_1 <= we_1 ? rows[head].opd : '0;
            free_preg_2 <= we_2 ? rows[head_p1].opd : '0;
        end
    end

endmodule
